// File: rtl/pwm_top.sv
// Multi-channel PWM generator: 5-beat UDP frames set per-channel freq/duty/enable, one shared engine derives counts.
// Latency ~20 clk from tlast to channel reload when the engine is idle; no backpressure, every valid beat is consumed.
module pwm_top #(
  parameter int PWM_NUM      = 5,
  parameter int ID_PWM_PARAM = 0,
  parameter int CLK_FREQ     = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        rx_axis_udp_tdata,
  input  logic               rx_axis_udp_tvalid,
  input  logic               rx_axis_udp_tlast,
  input  logic [7:0]         rx_axis_udp_tuser,
  output logic [PWM_NUM-1:0] pwm
);
  typedef struct packed {
    logic [31:0] freq;
    logic [6:0]  duty;
    logic        en;
  } cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_LOAD} state_t;

  localparam logic [8:0]  NUM_W = 9'(PWM_NUM);
  localparam logic [7:0]  ID_W  = 8'(ID_PWM_PARAM);
  localparam logic [31:0] CLK_W = 32'(CLK_FREQ);

  // ---------------- frame parser ----------------
  logic [2:0]  beat_q;
  logic        ok_q;
  logic [7:0]  chan_q;
  logic [31:0] freq_q;
  logic [6:0]  duty_q;
  logic        frame_done;

  // beat_q saturates at 5 so an over-long frame is ignored until its tlast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      ok_q   <= 1'b0;
      chan_q <= '0;
      freq_q <= '0;
      duty_q <= '0;
    end else if (rx_axis_udp_tvalid) begin
      if (rx_axis_udp_tlast) begin
        beat_q <= '0;
        ok_q   <= 1'b0;
      end else begin
        if (beat_q != 3'd5) beat_q <= beat_q + 3'd1;
        case (beat_q)
          3'd0: begin
            ok_q   <= (rx_axis_udp_tuser == ID_W) && ({1'b0, rx_axis_udp_tdata[7:0]} < NUM_W);
            chan_q <= rx_axis_udp_tdata[7:0];
          end
          3'd1: freq_q <= rx_axis_udp_tdata;
          3'd2: duty_q <= rx_axis_udp_tdata[6:0];
          default: ;
        endcase
      end
    end
  end

  assign frame_done = rx_axis_udp_tvalid && rx_axis_udp_tlast && (beat_q == 3'd4) && ok_q;

  // ---------------- pending storage and round-robin pick ----------------
  cfg_t               pend_q [PWM_NUM];
  logic [PWM_NUM-1:0] pend_vld_q;
  logic [PWM_NUM-1:0] rot;
  logic [7:0]         ptr_q;
  logic [7:0]         pick_idx;
  logic [8:0]         cand;
  logic [8:0]         ptr_nxt;
  logic               any_pend;
  cfg_t               pick_cfg;
  logic               eng_pick, eng_step, eng_mul, eng_load;

  always_comb begin
    rot      = PWM_NUM'({pend_vld_q, pend_vld_q} >> ptr_q);
    any_pend = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < PWM_NUM; i++) begin
      if (!any_pend && rot[i]) begin
        any_pend = 1'b1;
        cand     = {1'b0, ptr_q} + 9'(i);
        if (cand >= NUM_W) cand = cand - NUM_W;
        pick_idx = cand[7:0];
      end
    end
    pick_cfg = '0;
    for (int i = 0; i < PWM_NUM; i++) begin
      if (pick_idx == 8'(i)) pick_cfg = pend_q[i];
    end
    ptr_nxt = {1'b0, pick_idx} + 9'd1;
    if (ptr_nxt >= NUM_W) ptr_nxt = '0;
  end

  // A new frame landing on the cycle its channel is picked keeps the flag set, so it is serviced again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PWM_NUM; i++) pend_q[i] <= '0;
      pend_vld_q <= '0;
    end else begin
      for (int i = 0; i < PWM_NUM; i++) begin
        if (frame_done && chan_q == 8'(i)) begin
          pend_q[i]     <= '{freq: freq_q, duty: duty_q, en: rx_axis_udp_tdata[0]};
          pend_vld_q[i] <= 1'b1;
        end else if (eng_pick && pick_idx == 8'(i)) begin
          pend_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- compute engine FSM ----------------
  state_t      state_q, state_d;
  logic [3:0]  step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_pend) state_d = S_DIV;
      S_DIV:   if (step_q == 4'd15) state_d = S_MUL;
      S_MUL:   state_d = S_LOAD;
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_pick = (state_q == S_IDLE) && any_pend;
    eng_step = (state_q == S_DIV);
    eng_mul  = (state_q == S_MUL);
    eng_load = (state_q == S_LOAD);
  end

  // ---------------- engine datapath: radix-4 restoring divide, then scale ----------------
  cfg_t        cur_q;
  logic [7:0]  sel_q;
  logic [31:0] rem_q, dvd_q, quo_q, per_q;
  logic [38:0] prod_q;
  logic [32:0] r1s, r2s;
  logic [31:0] r1, r2, per_w, high_w;
  logic        ge1, ge2;
  logic [6:0]  duty_sat;

  always_comb begin
    r1s      = {rem_q, dvd_q[31]};
    ge1      = r1s >= {1'b0, cur_q.freq};
    r1       = ge1 ? 32'(r1s - {1'b0, cur_q.freq}) : r1s[31:0];
    r2s      = {r1, dvd_q[30]};
    ge2      = r2s >= {1'b0, cur_q.freq};
    r2       = ge2 ? 32'(r2s - {1'b0, cur_q.freq}) : r2s[31:0];
    per_w    = (cur_q.freq == 32'd0 || !cur_q.en) ? 32'd0 : quo_q;
    duty_sat = (cur_q.duty > 7'd100) ? 7'd100 : cur_q.duty;
    high_w   = 32'(prod_q / 39'd100);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      sel_q  <= '0;
      ptr_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      per_q  <= '0;
      prod_q <= '0;
    end else begin
      if (eng_pick) begin
        cur_q  <= pick_cfg;
        sel_q  <= pick_idx;
        ptr_q  <= ptr_nxt[7:0];
        rem_q  <= '0;
        dvd_q  <= CLK_W;
        quo_q  <= '0;
        step_q <= '0;
      end
      if (eng_step) begin
        rem_q  <= r2;
        dvd_q  <= {dvd_q[29:0], 2'b00};
        quo_q  <= {quo_q[29:0], ge1, ge2};
        step_q <= step_q + 4'd1;
      end
      if (eng_mul) begin
        per_q  <= per_w;
        prod_q <= {7'd0, per_w} * {32'd0, duty_sat};
      end
    end
  end

  // ---------------- per-channel counters and outputs ----------------
  logic [31:0]        act_per_q  [PWM_NUM];
  logic [31:0]        act_high_q [PWM_NUM];
  logic [31:0]        cnt_q      [PWM_NUM];
  logic [PWM_NUM-1:0] act_en_q;
  logic [PWM_NUM-1:0] pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PWM_NUM; i++) begin
        act_per_q[i]  <= '0;
        act_high_q[i] <= '0;
        cnt_q[i]      <= '0;
      end
      act_en_q <= '0;
      pwm_q    <= '0;
    end else begin
      for (int i = 0; i < PWM_NUM; i++) begin
        if (eng_load && sel_q == 8'(i)) begin
          act_per_q[i]  <= per_q;
          act_high_q[i] <= high_w;
          act_en_q[i]   <= cur_q.en;
          cnt_q[i]      <= '0;
        end else if (!act_en_q[i] || act_per_q[i] == 32'd0 || cnt_q[i] >= act_per_q[i] - 32'd1) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
        pwm_q[i] <= act_en_q[i] && (cnt_q[i] < act_high_q[i]);
      end
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_top.sv
// Bench for pwm_top: table-driven reconfiguration sets, rejected-frame cases, random configs vs a reference model.
`timescale 1ns/1ps
module tb_pwm_top;
  localparam int N    = 5;
  localparam int CLKF = 100000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  tdata;
  logic         tvalid, tlast;
  logic [7:0]   tuser;
  logic [N-1:0] pwm;

  pwm_top #(.PWM_NUM(N), .ID_PWM_PARAM(0), .CLK_FREQ(CLKF)) dut (
    .clk                (clk),
    .rst                (rst),
    .rx_axis_udp_tdata  (tdata),
    .rx_axis_udp_tvalid (tvalid),
    .rx_axis_udp_tlast  (tlast),
    .rx_axis_udp_tuser  (tuser),
    .pwm                (pwm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    int unsigned freq;
    int          duty;
    bit          en;
    int          per;
    int          hi;
  } vec_t;

  vec_t tbl [15];
  int   exp_per [N];
  int   exp_hi  [N];
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat, nz, maxp, idx, d;
  int unsigned f;
  bit   en;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: period = CLK/freq, high = period*min(duty,100)/100; disabled or freq 0 is flat low
  function automatic void model(input int unsigned fr, input int du, input bit e, output int per, output int hi);
    longint p;
    longint ds;
    if (!e || fr == 0) begin
      per = 0;
      hi  = 0;
    end else begin
      p   = longint'(CLKF) / longint'(fr);
      ds  = (du > 100) ? 100 : du;
      per = int'(p);
      hi  = int'((p * ds) / 100);
    end
  endfunction

  task automatic beat(input logic [31:0] dat, input logic l, input logic [7:0] u);
    @(negedge clk);
    tdata  = dat;
    tvalid = 1'b1;
    tlast  = l;
    tuser  = u;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic frame(input int ch, input int unsigned fr, input int du, input bit e, input logic [7:0] u);
    beat(32'(ch), 1'b0, u);
    beat(fr, 1'b0, u);
    beat(32'(du), 1'b0, u);
    beat(32'h0, 1'b0, u);
    beat({31'd0, e}, 1'b1, u);
  endtask

  // Observe all channels for win cycles; measure period/high from edges, or flat level when appropriate
  task automatic check_all(input int win, input string tag);
    int ones [N];
    int r1 [N];
    int f1 [N];
    int r2 [N];
    logic [N-1:0] prev, cur;
    for (int i = 0; i < N; i++) begin
      ones[i] = 0; r1[i] = -1; f1[i] = -1; r2[i] = -1;
    end
    @(negedge clk);
    prev = pwm;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      cur = pwm;
      for (int i = 0; i < N; i++) begin
        if (cur[i]) ones[i]++;
        if (cur[i] && !prev[i]) begin
          if (r1[i] < 0) r1[i] = c;
          else if (f1[i] >= 0 && r2[i] < 0) r2[i] = c;
        end
        if (!cur[i] && prev[i] && r1[i] >= 0 && f1[i] < 0) f1[i] = c;
      end
      prev = cur;
    end
    for (int i = 0; i < N; i++) begin
      if (exp_hi[i] == 0)
        check($sformatf("%s ch%0d low-cycles-high", tag, i), ones[i], 0);
      else if (exp_hi[i] == exp_per[i] || win < 2 * exp_per[i] + 10)
        check($sformatf("%s ch%0d high-cycles", tag, i), ones[i], win);
      else begin
        check($sformatf("%s ch%0d period", tag, i), r2[i] - r1[i], exp_per[i]);
        check($sformatf("%s ch%0d high", tag, i), f1[i] - r1[i], exp_hi[i]);
      end
    end
  endtask

  initial begin
    tdata = '0; tvalid = 1'b0; tlast = 1'b0; tuser = '0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin exp_per[i] = 0; exp_hi[i] = 0; end

    tbl[0]  = '{0, 100000, 100, 1'b1, 1000, 1000};
    tbl[1]  = '{1, 100000,  80, 1'b1, 1000, 800};
    tbl[2]  = '{2, 100000,  50, 1'b1, 1000, 500};
    tbl[3]  = '{3, 100000,  20, 1'b1, 1000, 200};
    tbl[4]  = '{4, 100000,   0, 1'b1, 1000, 0};
    tbl[5]  = '{0, 333333, 100, 1'b1, 300, 300};
    tbl[6]  = '{1, 333333,  80, 1'b1, 300, 240};
    tbl[7]  = '{2, 333333,  50, 1'b1, 300, 150};
    tbl[8]  = '{3, 333333,  20, 1'b1, 300, 60};
    tbl[9]  = '{4, 333333,   0, 1'b1, 300, 0};
    tbl[10] = '{0,   1000, 100, 1'b1, 100000, 100000};
    tbl[11] = '{1,   1000,  80, 1'b1, 100000, 80000};
    tbl[12] = '{2,   1000,  50, 1'b1, 100000, 50000};
    tbl[13] = '{3,   1000,  20, 1'b1, 100000, 20000};
    tbl[14] = '{4,   1000,   0, 1'b1, 100000, 0};

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset pwm", pwm, 0);

    // Single channel from idle must go active within 80 cycles of tlast
    frame(0, 100000, 100, 1'b1, 8'd0);
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (pwm[0] && lat < 0) lat = c;
    end
    check("ch0 active within 80 (1=yes)", (lat >= 1) ? 1 : 0, 1);

    // Table sets: all five channels back-to-back at 6-cycle spacing
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 5; k++) begin
        idx = s * 5 + k;
        frame(tbl[idx].ch, tbl[idx].freq, tbl[idx].duty, tbl[idx].en, 8'd0);
        @(posedge clk);
        exp_per[tbl[idx].ch] = tbl[idx].per;
        exp_hi[tbl[idx].ch]  = tbl[idx].hi;
      end
      repeat (80) @(posedge clk);
      check_all((s == 2) ? 2000 : 2 * tbl[s * 5].per + 20, $sformatf("set%0d", s));
    end

    // Rejected frames aimed at ch4 (would turn it constantly high if accepted)
    frame(4, 100000, 100, 1'b1, 8'd1);
    beat(32'd4, 1'b0, 8'd0); beat(32'd100000, 1'b0, 8'd0); beat(32'd101, 1'b1, 8'd0);
    frame(7, 100000, 100, 1'b1, 8'd0);
    beat(32'd4, 1'b0, 8'd0); beat(32'd100000, 1'b0, 8'd0); beat(32'd100, 1'b0, 8'd0);
    beat(32'd0, 1'b0, 8'd0); beat(32'd1, 1'b0, 8'd0); beat(32'd1, 1'b1, 8'd0);
    repeat (80) @(posedge clk);
    check_all(2000, "reject");

    // en=0 to ch2 with idle cycles inside the frame, then freq=0 to ch1
    beat(32'd2, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    beat(32'd100000, 1'b0, 8'd0);
    beat(32'd50, 1'b0, 8'd0);
    @(posedge clk);
    beat(32'd0, 1'b0, 8'd0);
    beat(32'd0, 1'b1, 8'd0);
    exp_per[2] = 0; exp_hi[2] = 0;
    frame(1, 0, 50, 1'b1, 8'd0);
    exp_per[1] = 0; exp_hi[1] = 0;
    repeat (80) @(posedge clk);
    check_all(2000, "disable");

    // Random configurations on all channels, checked against the model
    for (int t = 0; t < 6; t++) begin
      maxp = 0;
      for (int ch = 0; ch < N; ch++) begin
        f  = $urandom_range(50000000, 200000);
        d  = $urandom_range(127, 0);
        en = ($urandom_range(7, 0) != 0);
        frame(ch, f, d, en, 8'd0);
        repeat ($urandom_range(2, 0)) @(posedge clk);
        model(f, d, en, exp_per[ch], exp_hi[ch]);
        if (exp_per[ch] > maxp) maxp = exp_per[ch];
      end
      repeat (100) @(posedge clk);
      check_all(2 * maxp + 20, $sformatf("rand%0d", t));
    end

    // Asynchronous reset mid-operation
    frame(0, 100000, 100, 1'b1, 8'd0);
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("ch0 high before reset", pwm[0], 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("pwm cleared by async reset", pwm, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    nz = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (pwm != '0) nz++;
    end
    check("post-reset cycles with pwm nonzero", nz, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_top.md
Name: pwm_top

Overview:
- Multi-channel PWM generator configured over a 32-bit AXI-Stream-style UDP receive interface.
- Each configuration frame sets one channel's output frequency (Hz), duty cycle (percent) and enable.
- The block derives the period and high-time cycle counts from CLK_FREQ and drives PWM_NUM outputs.
- Sits behind the UDP stack's user receive port.

Parameters:
- PWM_NUM, 5, number of PWM channels (1..256).
- ID_PWM_PARAM, 0, frame ID in rx_axis_udp_tuser that marks a PWM parameter frame.
- CLK_FREQ, 100000000, clk frequency in Hz.

Ports:
- clk  in  1  module clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- rx_axis_udp_tdata  in  32  frame data word.
- rx_axis_udp_tvalid  in  1  data valid. No backpressure: every valid beat is consumed.
- rx_axis_udp_tlast  in  1  last beat of frame.
- rx_axis_udp_tuser  in  8  frame ID, held constant over the frame.
- pwm  out  PWM_NUM  PWM outputs, bit i = channel i.

Behaviour:
- Frame format, counted in valid beats:
  - beat0: tdata[7:0] = channel index.
  - beat1: tdata[31:0] = frequency in Hz.
  - beat2: tdata[6:0] = duty in percent.
  - beat3: reserved, ignored.
  - beat4: tdata[0] = enable, with tlast=1.
- Frame acceptance:
  - A frame is accepted only if tuser == ID_PWM_PARAM on beat0.
  - It must have exactly 5 beats, with tlast on beat4.
  - tlast before beat4 discards the frame.
  - If beat4 has no tlast, the frame is discarded and further beats are ignored until tlast.
  - A channel index >= PWM_NUM discards the frame.
- Beat counter: resets to 0 after every tlast beat. Idle cycles (tvalid=0) inside a frame are allowed.
- Pending storage:
  - An accepted frame writes that channel's pending {freq, duty, en} and sets its pending flag on the tlast cycle.
  - A newer frame to the same channel overwrites the pending values.
- Compute engine:
  - One shared engine services pending channels in round-robin order, lowest index first after reset.
  - period = floor(CLK_FREQ / freq), computed with a sequential 32-bit divider.
  - high = floor(period * min(duty,100) / 100).
  - It then loads the active registers of that channel, clears its pending flag, and restarts that channel's counter at 0.
- Latency: a single pending channel must be active no more than 80 clk cycles after its tlast beat. Frames may arrive back-to-back (6-cycle spacing); none may be lost.
- Per-channel output:
  - The counter runs 0..period-1 and wraps.
  - pwm = en && (cnt < high), registered.
  - duty 100 gives constant high while enabled; duty 0 gives constant low.
  - en=0 gives constant low, and the counter is held at 0.
- Illegal frequencies:
  - freq = 0, or freq > CLK_FREQ (period 0), is treated as disabled: output low.
  - period = 1 with duty 100 gives constant high.
- Reconfiguration applies immediately at load; the current period is truncated and no glitch filtering is done.
- Reset (asynchronous): pwm = 0, all channels disabled, counters 0, pending flags clear, parser and engine idle.

Test Plan:
- CLK_FREQ=100 MHz; configure channels 0..4 at 100000 Hz with duty 100/80/50/20/0, en=1:
  - period 1000 cycles.
  - high time: ch0 constant 1, ch1 800, ch2 500, ch3 200, ch4 constant 0.
- Reconfigure all channels to 333333 Hz:
  - period 300 cycles.
  - high time: ch1 240, ch2 150, ch3 60; ch0 stays 1, ch4 stays 0.
  - Active within 80 cycles of each tlast.
- Reconfigure all channels to 1000 Hz:
  - period 100000 cycles.
  - high time: ch1 80000, ch2 50000, ch3 20000.
- Frame with tuser != ID_PWM_PARAM, a 3-beat frame, or channel index 7 (PWM_NUM=5) -> all outputs unchanged.
- en=0 frame to ch2 -> pwm[2] low within 80 cycles. freq=0 to ch1 -> pwm[1] low.
- Assert rst mid-operation, asynchronously between clock edges -> all pwm = 0 immediately. After release, outputs stay 0 until new frames arrive.
